vga_scandoubler_ng: RTL



---
 rtl/scandbl_pkg.sv | 28 ++
 rtl/scandbl_linebuf.sv | 25 ++
 rtl/vga_scandoubler_ng.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/scandbl_pkg.sv
// Shared definitions for the VGA scandoubler: scanline-dimming encodings,
// dimming shift constants, vsync sequencer states and default sync widths.
package scandbl_pkg;

    // Scanline dimming selection carried on scan_mode
    typedef enum logic [1:0] {
        SCAN_OFF = 2'b00,
        SCAN_87  = 2'b01,
        SCAN_75  = 2'b10,
        SCAN_50  = 2'b11
    } scan_mode_e;

    // Right-shift amounts used by the dimming arithmetic
    localparam int unsigned DIM_SHIFT_87 = 32'd3;
    localparam int unsigned DIM_SHIFT_75 = 32'd2;
    localparam int unsigned DIM_SHIFT_50 = 32'd1;

    // Default output sync widths in clkvga cycles
    localparam int unsigned HSYNC_CYCLES_DEF = 32'd81;
    localparam int unsigned VSYNC_CYCLES_DEF = 32'd2744;

    // Output vsync sequencer states
    typedef enum logic {
        VS_IDLE = 1'b0,
        VS_LOW  = 1'b1
    } vs_state_e;

endpackage

// File: rtl/scandbl_linebuf.sv
// Two-bank line buffer: simple dual-port RAM, one write port and one
// registered read port. The bank select is the top address bit.
module scandbl_linebuf #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW:0]   raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:(2**(AW+1))-1];

    // Storage write and registered read; RAM contents are not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/vga_scandoubler_ng.sv
// VGA scandoubler: writes 15 kHz source lines into one buffer bank while
// replaying the previous line twice at 31 kHz from the other bank.
// Optional build macro SCANDBL_SYNCPOL_EN adds hpol/vpol polarity inputs;
// without it the output syncs are always active low.
module vga_scandoubler_ng
    import scandbl_pkg::*;
#(
    parameter int unsigned CW           = 3,
    parameter int unsigned OW           = 6,
    parameter int unsigned AW           = 10,
    parameter int unsigned HSYNC_CYCLES = HSYNC_CYCLES_DEF,
    parameter int unsigned VSYNC_CYCLES = VSYNC_CYCLES_DEF
) (
    input  logic          clkvga,
    input  logic          rst,
    input  logic          pix_ce,
    input  logic          en_scandbl,
    input  logic [1:0]    scan_mode,
    input  logic [CW-1:0] ri,
    input  logic [CW-1:0] gi,
    input  logic [CW-1:0] bi,
    input  logic          hsync_n,
    input  logic          vsync_n,
    input  logic          csync_n,
`ifdef SCANDBL_SYNCPOL_EN
    input  logic          hpol,
    input  logic          vpol,
`endif
    output logic [OW-1:0] ro,
    output logic [OW-1:0] go,
    output logic [OW-1:0] bo,
    output logic          hsync,
    output logic          vsync
);

    localparam int unsigned DW  = 3 * CW;
    localparam int unsigned VCW = (VSYNC_CYCLES < 32'd3) ? 32'd2 : $clog2(VSYNC_CYCLES + 32'd1);
    localparam logic [AW-1:0]  ADDR_MAX = {AW{1'b1}};
    localparam logic [AW-1:0]  ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [VCW-1:0] VS_LAST  = VCW'(VSYNC_CYCLES);
    localparam logic [VCW-1:0] VS_ONE   = {{(VCW-1){1'b0}}, 1'b1};

    // Scanline dimming on the native-width colour value
    function automatic logic [CW-1:0] dim_chan(input logic [CW-1:0] c, input logic [1:0] mode);
        logic [CW-1:0] r;
        case (mode)
            SCAN_87: r = c - (c >> DIM_SHIFT_87);
            SCAN_75: r = c - (c >> DIM_SHIFT_75);
            SCAN_50: r = c >> DIM_SHIFT_50;
            default: r = c;
        endcase
        return r;
    endfunction

    // Widen CW to OW by repeating the value MSB-first and truncating
    function automatic logic [OW-1:0] expand(input logic [CW-1:0] c);
        logic [OW-1:0] r;
        r = {OW{1'b0}};
        for (int i = 0; i < int'(OW); i++) begin
            r[int'(OW) - 1 - i] = c[int'(CW) - 1 - (i % int'(CW))];
        end
        return r;
    endfunction

    logic           hpol_s, vpol_s;
`ifdef SCANDBL_SYNCPOL_EN
    assign hpol_s = hpol;
    assign vpol_s = vpol;
`else
    assign hpol_s = 1'b0;
    assign vpol_s = 1'b0;
`endif

    // Write side state
    logic           hs_wr_prev_r, wr_bank_r;
    logic [AW-1:0]  wr_addr_r, totalhor_r;
    logic           hs_wr_fall_s, wr_en_s;
    // Read side state
    logic           hs_rd_prev_r, rd_bank_r, phase_r, phase_d1_r;
    logic [AW-1:0]  rd_addr_r, rd_addr_d1_r;
    logic [DW-1:0]  rd_data_s;
    // Vsync sequencer
    logic           vs_prev_r;
    vs_state_e      vs_state_r, vs_state_nxt_s;
    logic [VCW-1:0] vs_cnt_r, vs_cnt_nxt_s;
    // Next output values
    logic [1:0]     dim_mode_s;
    logic [OW-1:0]  ro_nxt_s, go_nxt_s, bo_nxt_s;
    logic           hsync_nxt_s, vsync_nxt_s;

    assign hs_wr_fall_s = hs_wr_prev_r & ~hsync_n;
    assign wr_en_s      = pix_ce & ~hs_wr_fall_s;

    scandbl_linebuf #(
        .AW (AW),
        .DW (DW)
    ) u_linebuf (
        .clk   (clkvga),
        .we    (wr_en_s),
        .waddr ({wr_bank_r, wr_addr_r}),
        .wdata ({ri, gi, bi}),
        .raddr ({rd_bank_r, rd_addr_r}),
        .rdata (rd_data_s)
    );

    // Source-rate write pointer: line length capture, bank swap, saturating address
    always_ff @(posedge clkvga or posedge rst) begin
        if (rst) begin
            hs_wr_prev_r <= 1'b1;
            wr_bank_r    <= 1'b0;
            wr_addr_r    <= {AW{1'b0}};
            totalhor_r   <= ADDR_MAX;
        end else if (pix_ce) begin
            hs_wr_prev_r <= hsync_n;
            if (hs_wr_fall_s) begin
                totalhor_r <= wr_addr_r;
                wr_bank_r  <= ~wr_bank_r;
                wr_addr_r  <= {AW{1'b0}};
            end else if (wr_addr_r != ADDR_MAX) begin
                wr_addr_r <= wr_addr_r + ADDR_ONE;
            end
        end
    end

    // Double-rate read pointer: restart on hsync edge, wrap into the repeat pass
    always_ff @(posedge clkvga or posedge rst) begin
        if (rst) begin
            hs_rd_prev_r <= 1'b1;
            rd_bank_r    <= 1'b0;
            rd_addr_r    <= {AW{1'b0}};
            phase_r      <= 1'b0;
            rd_addr_d1_r <= {AW{1'b0}};
            phase_d1_r   <= 1'b0;
        end else begin
            hs_rd_prev_r <= hsync_n;
            rd_addr_d1_r <= rd_addr_r;
            phase_d1_r   <= phase_r;
            if (hs_rd_prev_r & ~hsync_n) begin
                rd_bank_r <= wr_bank_r;
                rd_addr_r <= {AW{1'b0}};
                phase_r   <= 1'b0;
            end else if (rd_addr_r == totalhor_r) begin
                rd_addr_r <= {AW{1'b0}};
                phase_r   <= 1'b1;
            end else begin
                rd_addr_r <= rd_addr_r + ADDR_ONE;
            end
        end
    end

    // Vsync sequencer state register
    always_ff @(posedge clkvga or posedge rst) begin
        if (rst) begin
            vs_prev_r  <= 1'b1;
            vs_state_r <= VS_IDLE;
            vs_cnt_r   <= {VCW{1'b0}};
        end else begin
            vs_prev_r  <= vsync_n;
            vs_state_r <= vs_state_nxt_s;
            vs_cnt_r   <= vs_cnt_nxt_s;
        end
    end

    // Vsync next state: start on falling vsync_n, stop on rise or count expiry
    always_comb begin
        vs_state_nxt_s = vs_state_r;
        vs_cnt_nxt_s   = vs_cnt_r;
        if (vs_prev_r & ~vsync_n) begin
            vs_state_nxt_s = VS_LOW;
            vs_cnt_nxt_s   = {VCW{1'b0}};
        end else begin
            case (vs_state_r)
                VS_LOW: begin
                    if (vsync_n || (vs_cnt_r == VS_LAST)) begin
                        vs_state_nxt_s = VS_IDLE;
                    end else begin
                        vs_cnt_nxt_s = vs_cnt_r + VS_ONE;
                    end
                end
                VS_IDLE: vs_state_nxt_s = VS_IDLE;
                default: vs_state_nxt_s = VS_IDLE;
            endcase
        end
    end

    // Output selection: doubled path with dimming on the repeat pass, or bypass
    always_comb begin
        if (phase_d1_r) begin
            dim_mode_s = scan_mode;
        end else begin
            dim_mode_s = SCAN_OFF;
        end
        if (en_scandbl) begin
            ro_nxt_s    = expand(dim_chan(rd_data_s[3*CW-1:2*CW], dim_mode_s));
            go_nxt_s    = expand(dim_chan(rd_data_s[2*CW-1:CW], dim_mode_s));
            bo_nxt_s    = expand(dim_chan(rd_data_s[CW-1:0], dim_mode_s));
            hsync_nxt_s = (32'(rd_addr_d1_r) >= HSYNC_CYCLES) ^ hpol_s;
            vsync_nxt_s = (vs_state_nxt_s != VS_LOW) ^ vpol_s;
        end else begin
            ro_nxt_s    = expand(ri);
            go_nxt_s    = expand(gi);
            bo_nxt_s    = expand(bi);
            hsync_nxt_s = csync_n ^ hpol_s;
            vsync_nxt_s = 1'b1 ^ vpol_s;
        end
    end

    // Registered outputs
    always_ff @(posedge clkvga or posedge rst) begin
        if (rst) begin
            ro    <= {OW{1'b0}};
            go    <= {OW{1'b0}};
            bo    <= {OW{1'b0}};
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            ro    <= ro_nxt_s;
            go    <= go_nxt_s;
            bo    <= bo_nxt_s;
            hsync <= hsync_nxt_s;
            vsync <= vsync_nxt_s;
        end
    end

endmodule
